// File: rtl/arp_rx_filter.sv
// ARP receive parser: walks the header beats of each ARP frame, validates it and
// raises learn / reply / conflict pulses on the cycle after its last beat.
module arp_rx_filter #(
    parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
    parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06,
    parameter int          P_USER_WIDTH   = 80,
    parameter int          P_CNT_WIDTH    = 16,
    parameter bit          P_CHECK_HDR    = 1'b1,
    parameter bit          P_LEARN_ALL    = 1'b0,
    parameter bit          P_GRAT_EN      = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [31:0]             i_dymanic_src_ip,
    input  logic                    i_src_ip_valid,
    input  logic [63:0]             s_axis_mac_data,
    input  logic [P_USER_WIDTH-1:0] s_axis_mac_user,
    input  logic [7:0]              s_axis_mac_keep,
    input  logic                    s_axis_mac_last,
    input  logic                    s_axis_mac_valid,
    output logic [47:0]             o_recv_target_mac,
    output logic [31:0]             o_recv_target_ip,
    output logic                    o_recv_target_valid,
    output logic                    o_recv_is_reply,
    output logic                    o_arp_reply,
    output logic                    o_ip_conflict,
    output logic [P_CNT_WIDTH-1:0]  o_rx_arp_cnt,
    output logic [P_CNT_WIDTH-1:0]  o_rx_drop_cnt
);

    // HDR is folded into IDLE/DECIDE: both capture b0 directly.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BODY    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_DECIDE  = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_beat;
    logic [15:0] r_htype;
    logic [15:0] r_ptype;
    logic [7:0]  r_hlen;
    logic [7:0]  r_plen;
    logic [15:0] r_oper;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic [31:0] r_tpa;
    logic [31:0] r_local_ip;
    logic [P_CNT_WIDTH-1:0] r_arp_cnt;
    logic [P_CNT_WIDTH-1:0] r_drop_cnt;

    logic w_decide, w_start, w_is_arp, w_oper_ok, w_hdr_ok;
    logic w_grat, w_mine, w_conflict, w_learn, w_reply;
    logic w_short_b0, w_short_body, w_arp_inc;
    logic [1:0] w_drop_inc;
    logic [P_CNT_WIDTH:0] w_drop_sum;
    logic [P_CNT_WIDTH:0] w_arp_sum;
    logic w_unused_ok;

    assign w_decide   = (r_state == S_DECIDE);
    assign w_start    = s_axis_mac_valid && (r_state == S_IDLE || r_state == S_DECIDE);
    assign w_is_arp   = (s_axis_mac_user[15:0] == 16'h0806);
    assign w_oper_ok  = (r_oper == 16'd1) || (r_oper == 16'd2);
    assign w_hdr_ok   = w_oper_ok && (!P_CHECK_HDR ||
                        (r_htype == 16'd1 && r_ptype == 16'h0800 && r_hlen == 8'd6 && r_plen == 8'd4));
    assign w_grat     = (r_spa == r_tpa);
    assign w_mine     = (r_tpa == r_local_ip);
    assign w_conflict = (r_spa == r_local_ip);
    assign w_learn    = w_decide && w_hdr_ok && !w_conflict && (w_mine || P_LEARN_ALL || (w_grat && P_GRAT_EN));
    assign w_reply    = w_decide && w_hdr_ok && !w_conflict && (r_oper == 16'd1) && w_mine && !w_grat;

    // A b0-only frame can end during DECIDE, so two drops may land in one cycle.
    assign w_short_b0   = w_start && w_is_arp && s_axis_mac_last;
    assign w_short_body = (r_state == S_BODY) && s_axis_mac_valid && s_axis_mac_last && (r_beat < 3'd3);
    assign w_drop_inc   = {1'b0, w_short_b0} + {1'b0, w_short_body || (w_decide && !w_hdr_ok)};
    assign w_arp_inc    = w_decide && w_hdr_ok;
    assign w_drop_sum   = {1'b0, r_drop_cnt} + {{(P_CNT_WIDTH-1){1'b0}}, w_drop_inc};
    assign w_arp_sum    = {1'b0, r_arp_cnt} + {{P_CNT_WIDTH{1'b0}}, w_arp_inc};

    assign o_recv_target_valid = w_learn;
    assign o_recv_is_reply     = w_learn && (r_oper == 16'd2);
    assign o_recv_target_mac   = w_learn ? r_sha : 48'd0;
    assign o_recv_target_ip    = w_learn ? r_spa : 32'd0;
    assign o_arp_reply         = w_reply;
    assign o_ip_conflict       = w_decide && w_hdr_ok && w_conflict;
    assign o_rx_arp_cnt        = r_arp_cnt;
    assign o_rx_drop_cnt       = r_drop_cnt;

    assign w_unused_ok = ^{s_axis_mac_keep, s_axis_mac_user[P_USER_WIDTH-1:16], P_SRC_MAC_ADDR};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= 3'd0;
            r_htype <= 16'd0;
            r_ptype <= 16'd0;
            r_hlen  <= 8'd0;
            r_plen  <= 8'd0;
            r_oper  <= 16'd0;
            r_sha   <= 48'd0;
            r_spa   <= 32'd0;
            r_tpa   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DECIDE: begin
                    if (s_axis_mac_valid) begin
                        if (w_is_arp) begin
                            r_htype <= s_axis_mac_data[63:48];
                            r_ptype <= s_axis_mac_data[47:32];
                            r_hlen  <= s_axis_mac_data[31:24];
                            r_plen  <= s_axis_mac_data[23:16];
                            r_oper  <= s_axis_mac_data[15:0];
                            r_beat  <= 3'd1;
                            r_state <= s_axis_mac_last ? S_IDLE : S_BODY;
                        end else begin
                            r_state <= s_axis_mac_last ? S_IDLE : S_DISCARD;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BODY: begin
                    if (s_axis_mac_valid) begin
                        case (r_beat)
                            3'd1: begin
                                r_sha          <= s_axis_mac_data[63:16];
                                r_spa[31:16]   <= s_axis_mac_data[15:0];
                            end
                            3'd2: r_spa[15:0]  <= s_axis_mac_data[63:48];
                            3'd3: r_tpa        <= s_axis_mac_data[63:32];
                            default: ;
                        endcase
                        if (r_beat != 3'd4) r_beat <= r_beat + 3'd1;
                        if (s_axis_mac_last) r_state <= (r_beat >= 3'd3) ? S_DECIDE : S_IDLE;
                    end
                end
                default: begin
                    if (s_axis_mac_valid && s_axis_mac_last) r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The decision reads r_local_ip before a coinciding load lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_local_ip <= P_SRC_IP_ADDR;
        end else if (i_src_ip_valid) begin
            r_local_ip <= i_dymanic_src_ip;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arp_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_arp_cnt  <= w_arp_sum[P_CNT_WIDTH]  ? '1 : w_arp_sum[P_CNT_WIDTH-1:0];
            r_drop_cnt <= w_drop_sum[P_CNT_WIDTH] ? '1 : w_drop_sum[P_CNT_WIDTH-1:0];
        end
    end

endmodule

// File: doc/arp_rx_filter.md
Name: arp_rx_filter

Overview:
- Parametrised next-generation ARP receive parser. Sits between the 10G MAC RX AXI-Stream output (Ethernet header already stripped, EtherType in tuser[15:0]) and the ARP TX and ARP table logic.
- Runs a beat-counting FSM that tolerates valid gaps and validates the ARP header fields.
- Classifies each frame as request, reply, gratuitous or IP conflict, and qualifies learn and reply events on the frame's last beat only.
- Keeps saturating frame statistics.

Parameters:
- P_SRC_IP_ADDR, {8'd192,8'd168,8'd100,8'd99}: local IP loaded at reset.
- P_SRC_MAC_ADDR, 48'h01_02_03_04_05_06: local MAC. Reserved; not compared in this revision.
- P_USER_WIDTH, 80: tuser width. EtherType is always tuser[15:0].
- P_CNT_WIDTH, 16: width of the statistics counters.
- P_CHECK_HDR, 1: 1 = require HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4 and OPER in {1,2}. 0 = require OPER in {1,2} only.
- P_LEARN_ALL, 0: 1 = learn the sender of every valid ARP frame. 0 = learn only when TPA equals the local IP.
- P_GRAT_EN, 1: 1 = learn from gratuitous ARP (SPA==TPA) regardless of TPA match.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dymanic_src_ip  in  32  new local IP
- i_src_ip_valid  in  1  load i_dymanic_src_ip into the local IP register
- s_axis_mac_data  in  64  frame data, big-endian, first byte in [63:56]
- s_axis_mac_user  in  P_USER_WIDTH  [15:0] = EtherType
- s_axis_mac_keep  in  8  byte enables (ignored)
- s_axis_mac_last  in  1  last beat of frame
- s_axis_mac_valid  in  1  beat valid. Gaps allowed; no tready.
- o_recv_target_mac  out  48  learned sender MAC (SHA)
- o_recv_target_ip  out  32  learned sender IP (SPA)
- o_recv_target_valid  out  1  one-cycle learn strobe
- o_recv_is_reply  out  1  qualifies o_recv_target_valid: OPER was 2
- o_arp_reply  out  1  one-cycle pulse: send an ARP reply to o_recv_target_mac/ip
- o_ip_conflict  out  1  one-cycle pulse: SPA equals the local IP
- o_rx_arp_cnt  out  P_CNT_WIDTH  count of accepted ARP frames
- o_rx_drop_cnt  out  P_CNT_WIDTH  count of ARP-EtherType frames dropped (malformed or short)

Behaviour:
- Reset: all outputs 0, counters 0, local IP = P_SRC_IP_ADDR, FSM in IDLE. The first valid beat after reset is treated as a start of frame.
- Local IP register: loaded on i_src_ip_valid. A load coinciding with a decision cycle takes effect after it; the decision uses the old IP.
- Beat layout (beat index counts valid beats only):
  - b0: HTYPE[63:48], PTYPE[47:32], HLEN[31:24], PLEN[23:16], OPER[15:0]
  - b1: SHA[63:16], SPA[31:16] in [15:0]
  - b2: SPA[15:0] in [63:48], THA[47:0]
  - b3: TPA[63:32]
  - beats after b3 are padding and ignored.
- FSM states: IDLE, HDR, BODY, DISCARD, DECIDE.
  - IDLE: on valid, if user[15:0]==16'h0806, capture b0 fields and go to BODY. Otherwise go to DISCARD (not counted). If valid && last on b0, the frame is short: increment o_rx_drop_cnt, stay in IDLE.
  - BODY: capture b1–b3 as beats arrive.
    - Invalid cycles hold state.
    - last before b3 → short frame: increment drop count, go to IDLE.
    - last at or after b3 → go to DECIDE.
  - DISCARD: wait for valid && last, then go to IDLE.
  - DECIDE: single cycle. Evaluate, pulse outputs, go to IDLE.
  - A valid beat in the DECIDE cycle is a new frame's b0. It must be handled exactly as in IDLE, i.e. back-to-back frames are supported.
  - HDR is an alias for IDLE's b0 capture and may be merged with IDLE in the implementation.
- DECIDE evaluation: hdr_ok per P_CHECK_HDR; grat = (SPA==TPA); mine = (TPA==local IP).
  - !hdr_ok → drop count +1, no pulses.
  - else arp count +1, then apply the following:
    - SPA==local IP → o_ip_conflict=1, no learn, no reply.
    - else learn = mine | P_LEARN_ALL | (grat & P_GRAT_EN).
    - On learn: o_recv_target_valid=1 with SHA/SPA; o_recv_is_reply = (OPER==2).
    - reply = (OPER==1) & mine & !grat → o_arp_reply=1, concurrent with the learn strobe.
- Output timing:
  - All pulses are high for exactly one cycle, one cycle after the last beat is accepted.
  - o_recv_target_mac/ip hold the captured value during the strobe and return to 0 otherwise.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-frame aborts the frame with no pulses and no count.

Test Plan:
- ARP request, 4 beats, SPA=192.168.100.1, SHA=0x00AABBCCDDEE, TPA=192.168.100.99 → one cycle after last: o_recv_target_valid=1, mac=0x00AABBCCDDEE, ip=0xC0A86401, o_recv_is_reply=0, o_arp_reply=1, o_rx_arp_cnt=1.
- Same frame with TPA=192.168.100.50 and P_LEARN_ALL=0 → no pulses, o_rx_arp_cnt=1. Then a reply (OPER=2) to .99 → learn strobe with o_recv_is_reply=1 and o_arp_reply=0.
- Gratuitous frame, SPA=TPA=192.168.100.7 → learn strobe, o_arp_reply=0. SPA=TPA=192.168.100.99 → o_ip_conflict=1, no learn.
- HTYPE=2 frame with P_CHECK_HDR=1 → o_rx_drop_cnt=1. A 2-beat ARP frame ending on b1 → drop count +1. EtherType 0x0800 frame → no counters change.
- Request with valid deasserted for 3 cycles between b1 and b2, followed back-to-back (no idle cycle) by a second request → two correct reply pulses.
- i_src_ip_valid loading 10.0.0.5, then a request to 10.0.0.5 → o_arp_reply=1. Reset asserted at b2 → no pulses; the next full frame is processed normally.
